// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve/play/score/over FSM, miss detection and per-player scores.
// Define PONG_PAUSE_EN to add in_button_pause and the PAUSE state.
module pong_game_ctrl #(
   parameter int unsigned D_WIDTH      = 639,
   parameter int unsigned WIN_SCORE    = 5,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned SCORE_FRAMES = 90,
   parameter int unsigned SCORE_W      = 4
) (
   input  logic               in_clock,
   input  logic               in_reset,
   input  logic               in_ani_stb,
   input  logic               in_button_start,
`ifdef PONG_PAUSE_EN
   input  logic               in_button_pause,
`endif
   input  logic [11:0]        in_ball_x1,
   input  logic [11:0]        in_ball_x2,
   output logic               out_animate,
   output logic               out_obj_reset,
   output logic               out_serve_dir,
   output logic [SCORE_W-1:0] out_score_l,
   output logic [SCORE_W-1:0] out_score_r,
   output logic [2:0]         out_state,
   output logic               out_winner
);

   localparam int unsigned MaxFrames =
      (SERVE_FRAMES > SCORE_FRAMES) ? SERVE_FRAMES : SCORE_FRAMES;
   localparam int unsigned FcntW = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StServe = 3'd1,
      StPlay  = 3'd2,
      StScore = 3'd3,
      StOver  = 3'd4,
      StPause = 3'd5
   } state_e;

   state_e             state_q;
   logic [FcntW-1:0]   fcnt_q;
   logic [SCORE_W-1:0] score_l_q, score_r_q;
   logic               serve_dir_q, winner_q, obj_reset_q, start_prev_q;

   logic start_press, pause_press, serve_last, score_last, win_hit, r_wins;

   assign start_press = in_button_start & ~start_prev_q;
   assign serve_last  = (fcnt_q == FcntW'(SERVE_FRAMES - 1));
   assign score_last  = (fcnt_q == FcntW'(SCORE_FRAMES - 1));
   assign r_wins      = (score_r_q == SCORE_W'(WIN_SCORE));
   assign win_hit     = r_wins | (score_l_q == SCORE_W'(WIN_SCORE));

`ifdef PONG_PAUSE_EN
   logic pause_prev_q;

   assign pause_press = in_button_pause & ~pause_prev_q;

   always_ff @(posedge in_clock) begin
      if (in_reset) pause_prev_q <= 1'b1;
      else          pause_prev_q <= in_button_pause;
   end
`else
   // Without the pause feature StPause is never entered.
   assign pause_press = 1'b0;
`endif

   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         state_q      <= StIdle;
         fcnt_q       <= '0;
         score_l_q    <= '0;
         score_r_q    <= '0;
         serve_dir_q  <= 1'b0;
         winner_q     <= 1'b0;
         obj_reset_q  <= 1'b0;
         start_prev_q <= 1'b1;
      end else begin
         start_prev_q <= in_button_start;
         obj_reset_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_press) begin
                  score_l_q   <= '0;
                  score_r_q   <= '0;
                  fcnt_q      <= '0;
                  obj_reset_q <= 1'b1;
                  state_q     <= StServe;
               end
            end
            StServe: begin
               if (in_ani_stb) begin
                  if (serve_last) begin
                     fcnt_q  <= '0;
                     state_q <= StPlay;
                  end else begin
                     fcnt_q <= fcnt_q + 1'b1;
                  end
               end
            end
            StPlay: begin
               if (pause_press) begin
                  state_q <= StPause;
               end else if (in_ani_stb) begin
                  // Left-edge miss wins when both edges are out of the field.
                  if (in_ball_x1 == '0) begin
                     score_r_q   <= score_r_q + 1'b1;
                     serve_dir_q <= 1'b0;
                     fcnt_q      <= '0;
                     state_q     <= StScore;
                  end else if (in_ball_x2 >= 12'(D_WIDTH)) begin
                     score_l_q   <= score_l_q + 1'b1;
                     serve_dir_q <= 1'b1;
                     fcnt_q      <= '0;
                     state_q     <= StScore;
                  end
               end
            end
            StScore: begin
               if (in_ani_stb) begin
                  if (score_last) begin
                     fcnt_q <= '0;
                     if (win_hit) begin
                        winner_q <= r_wins;
                        state_q  <= StOver;
                     end else begin
                        obj_reset_q <= 1'b1;
                        state_q     <= StServe;
                     end
                  end else begin
                     fcnt_q <= fcnt_q + 1'b1;
                  end
               end
            end
            StOver: begin
               if (start_press) begin
                  score_l_q   <= '0;
                  score_r_q   <= '0;
                  winner_q    <= 1'b0;
                  fcnt_q      <= '0;
                  obj_reset_q <= 1'b1;
                  state_q     <= StServe;
               end
            end
            StPause: begin
               if (pause_press) state_q <= StPlay;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_animate   = (state_q == StPlay);
   assign out_obj_reset = obj_reset_q;
   assign out_serve_dir = serve_dir_q;
   assign out_score_l   = score_l_q;
   assign out_score_r   = score_r_q;
   assign out_state     = state_q;
   assign out_winner    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_pong_game_ctrl;

   localparam logic [11:0] X1 = 12'd100;
   localparam logic [11:0] X2 = 12'd200;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       stb = 1'b0;
   logic       start = 1'b0;
   logic [11:0] ball_x1 = X1;
   logic [11:0] ball_x2 = X2;
`ifdef PONG_PAUSE_EN
   logic       pause = 1'b0;
`endif
   logic       animate, obj_reset, serve_dir, winner;
   logic [3:0] score_l, score_r;
   logic [2:0] state;

   pong_game_ctrl #(
      .D_WIDTH      (639),
      .WIN_SCORE    (2),
      .SERVE_FRAMES (2),
      .SCORE_FRAMES (3),
      .SCORE_W      (4)
   ) dut (
      .in_clock        (clk),
      .in_reset        (rst),
      .in_ani_stb      (stb),
      .in_button_start (start),
`ifdef PONG_PAUSE_EN
      .in_button_pause (pause),
`endif
      .in_ball_x1      (ball_x1),
      .in_ball_x2      (ball_x2),
      .out_animate     (animate),
      .out_obj_reset   (obj_reset),
      .out_serve_dir   (serve_dir),
      .out_score_l     (score_l),
      .out_score_r     (score_r),
      .out_state       (state),
      .out_winner      (winner)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      int         cyc;
      logic [2:0] st;
      logic       anim;
      logic       orst;
      logic       dir;
      logic [3:0] sl;
      logic [3:0] sr;
      logic       win;
   } exp_t;

   exp_t exp_q[$];
   int   cyc_cnt  = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Inputs change 1 time unit after a posedge and are consumed by the next one.
   task automatic tick(input logic r, input logic s, input logic st,
                       input logic [11:0] x1, input logic [11:0] x2);
      @(posedge clk);
      #1;
      rst = r; stb = s; start = st; ball_x1 = x1; ball_x2 = x2;
`ifdef PONG_PAUSE_EN
      pause = 1'b0;
`endif
   endtask

`ifdef PONG_PAUSE_EN
   task automatic ptick(input logic p, input logic s, input logic [11:0] x1,
                        input logic [11:0] x2);
      @(posedge clk);
      #1;
      rst = 1'b0; stb = s; start = 1'b0; ball_x1 = x1; ball_x2 = x2; pause = p;
   endtask
`endif

   // Expected outputs after the edge that consumes the inputs just driven.
   task automatic chk(input string n, input logic [2:0] st, input logic anim, input logic orst,
                      input logic dir, input logic [3:0] sl, input logic [3:0] sr,
                      input logic win);
      exp_t e;
      e.name = n; e.cyc = cyc_cnt + 1; e.st = st; e.anim = anim; e.orst = orst;
      e.dir = dir; e.sl = sl; e.sr = sr; e.win = win;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            e = exp_q.pop_front();
            n_checks++;
            if (e.cyc < cyc_cnt) begin
               n_fail++;
               $display("FAIL %s: sample missed (due cycle %0d, now %0d)", e.name, e.cyc,
                        cyc_cnt);
            end else if ({state, animate, obj_reset, serve_dir, score_l, score_r, winner} !==
                         {e.st, e.anim, e.orst, e.dir, e.sl, e.sr, e.win}) begin
               n_fail++;
               $display({"FAIL %s: got st=%0d anim=%0b orst=%0b dir=%0b sl=%0d sr=%0d win=%0b",
                         " | need st=%0d anim=%0b orst=%0b dir=%0b sl=%0d sr=%0d win=%0b"},
                        e.name, state, animate, obj_reset, serve_dir, score_l, score_r, winner,
                        e.st, e.anim, e.orst, e.dir, e.sl, e.sr, e.win);
            end
         end
      end
   end

   initial begin : stimulus
      // Reset and first serve
      tick(1, 0, 0, X1, X2);  chk("reset",          0, 0, 0, 0, 0, 0, 0);
      tick(0, 1, 0, X1, X2);  chk("idle_stb",       0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 1, X1, X2);  chk("start",          1, 0, 1, 0, 0, 0, 0);
      tick(0, 0, 0, X1, X2);  chk("serve_pulse_end",1, 0, 0, 0, 0, 0, 0);
      tick(0, 1, 0, X1, X2);  chk("serve_f1",       1, 0, 0, 0, 0, 0, 0);
      tick(0, 1, 0, X1, X2);  chk("play",           2, 1, 0, 0, 0, 0, 0);
      // Left miss
      tick(0, 0, 0, 0, X2);   chk("x1_nostb",       2, 1, 0, 0, 0, 0, 0);
      tick(0, 1, 0, 0, X2);   chk("miss_left",      3, 0, 0, 0, 0, 1, 0);
      tick(0, 1, 0, X1, X2);  chk("score_f1",       3, 0, 0, 0, 0, 1, 0);
      tick(0, 1, 0, X1, X2);
      tick(0, 1, 0, X1, X2);  chk("score_to_serve", 1, 0, 1, 0, 0, 1, 0);
      tick(0, 1, 0, X1, X2);
      tick(0, 1, 0, X1, X2);  chk("play2",          2, 1, 0, 0, 0, 1, 0);
      // Right miss, strobe-gated
      tick(0, 0, 0, X1, 639); chk("x2_nostb",       2, 1, 0, 0, 0, 1, 0);
      tick(0, 1, 0, X1, 639); chk("miss_right",     3, 0, 0, 1, 1, 1, 0);
      tick(0, 1, 0, X1, X2);
      tick(0, 1, 0, X1, X2);
      tick(0, 1, 0, X1, X2);  chk("serve3",         1, 0, 1, 1, 1, 1, 0);
      tick(0, 1, 0, X1, X2);
      tick(0, 1, 0, X1, X2);  chk("play3",          2, 1, 0, 1, 1, 1, 0);
`ifdef PONG_PAUSE_EN
      ptick(1, 0, X1, X2);    chk("pause",          5, 0, 0, 1, 1, 1, 0);
      ptick(0, 1, 0, X2);     chk("paused_stb",     5, 0, 0, 1, 1, 1, 0);
      ptick(1, 0, X1, X2);    chk("resume",         2, 1, 0, 1, 1, 1, 0);
`endif
      // Both edges out: only the right player scores, then match over
      tick(0, 1, 0, 0, 639);  chk("both_miss",      3, 0, 0, 0, 1, 2, 0);
      tick(0, 0, 1, X1, X2);  chk("start_ign_score",3, 0, 0, 0, 1, 2, 0);
      tick(0, 1, 0, X1, X2);
      tick(0, 1, 0, X1, X2);
      tick(0, 1, 0, X1, X2);  chk("over",           4, 0, 0, 0, 1, 2, 1);
      tick(0, 1, 0, X1, X2);  chk("over_hold",      4, 0, 0, 0, 1, 2, 1);
      tick(0, 0, 1, X1, X2);  chk("restart",        1, 0, 1, 0, 0, 0, 0);
      tick(0, 1, 0, X1, X2);
      tick(0, 1, 0, X1, X2);  chk("play4",          2, 1, 0, 0, 0, 0, 0);
      tick(0, 1, 0, X1, 700); chk("miss_right2",    3, 0, 0, 1, 1, 0, 0);
      // Reset mid-match, then start held through reset
      tick(1, 1, 0, X1, X2);  chk("reset_mid",      0, 0, 0, 0, 0, 0, 0);
      tick(1, 0, 1, X1, X2);  chk("reset_held",     0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 1, X1, X2);  chk("held_no_start",  0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 1, X1, X2);  chk("held_no_start2", 0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, X1, X2);  chk("released",       0, 0, 0, 0, 0, 0, 0);
      tick(0, 0, 1, X1, X2);  chk("repress",        1, 0, 1, 0, 0, 0, 0);
      tick(0, 0, 0, X1, X2);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations never sampled, need 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit reached, need completion");
      $fatal(1, "timeout");
   end

endmodule
